// File: rtl/adc_buffer_reader.sv
// adc_buffer_reader
// Streams a completed ADC capture out of the capture buffer, in address
// order, over a valid/ready interface. A 2-entry output FIFO covers the
// buffer's 1-cycle read latency so the stream runs at one sample per clock.
//
// Ports
//   adc_clock      in   single clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   capture_done   in   buffer holds a complete capture (level)
//   start_readout  in   request a readout, sampled in IDLE only
//   abort          in   synchronous abort of a running readout
//   read_addr      out  buffer read address (registered)
//   read_data      in   buffer data for the address currently presented
//   m_data         out  stream sample (FIFO head)
//   m_valid        out  m_data is valid
//   m_ready        in   downstream accepts
//   m_last         out  head sample is from address DEPTH-1
//   busy           out  readout in progress
//   readout_done   out  last sample transferred; cleared by next accepted start
//
// state  | meaning
// S_IDLE | waiting for start_readout with capture_done
// S_RUN  | issuing reads and streaming samples
module adc_buffer_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  adc_clock,
  input  logic                  reset_n,
  input  logic                  capture_done,
  input  logic                  start_readout,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  readout_done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_LAST  = CW'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_issued;        // reads issued; low bits are the read pointer
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_wr_idx;
  logic                  r_rd_idx;
  logic [1:0]            r_count;
  logic                  r_done;

  logic       w_run;
  logic       w_start;
  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_last_xfer;
  logic [2:0] w_occ;

  assign w_run   = (r_state == S_RUN);
  assign w_start = !w_run && start_readout && capture_done && !abort;
  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_run && w_valid && m_ready;
  assign w_push  = w_run && r_inflight && !abort;

  // The slot freed by this cycle's pop is credited to the issue decision;
  // without it a 2-entry FIFO cannot cover the read latency at full rate.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = w_run && !abort && (r_issued < LP_DEPTH) && (w_occ < 3'd2);

  assign w_last_xfer = w_pop && r_fifo_last[r_rd_idx];

  always_ff @(posedge adc_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_issued        <= '0;
      r_read_addr     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_data[0]  <= '0;
      r_fifo_data[1]  <= '0;
      r_fifo_last     <= 2'b00;
      r_wr_idx        <= 1'b0;
      r_rd_idx        <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_RUN;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_wr_idx   <= 1'b0;
            r_rd_idx   <= 1'b0;
            r_count    <= 2'd0;
            r_done     <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Drop everything buffered or in flight; readout_done stays low.
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_wr_idx   <= 1'b0;
            r_rd_idx   <= 1'b0;
            r_count    <= 2'd0;
          end else begin
            if (w_issue) begin
              r_read_addr     <= r_issued[ADDR_WIDTH-1:0];
              r_issued        <= r_issued + 1'b1;
              r_inflight      <= 1'b1;
              r_inflight_last <= (r_issued == LP_LAST);
            end else begin
              r_inflight <= 1'b0;
            end
            if (w_push) begin
              r_fifo_data[r_wr_idx] <= read_data;
              r_fifo_last[r_wr_idx] <= r_inflight_last;
              r_wr_idx              <= ~r_wr_idx;
            end
            if (w_pop) begin
              r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_last_xfer) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign read_addr    = r_read_addr;
  assign m_data       = r_fifo_data[r_rd_idx];
  assign m_valid      = w_valid;
  assign m_last       = w_valid && r_fifo_last[r_rd_idx];
  assign busy         = w_run;
  assign readout_done = r_done;

  a_fifo_no_overflow: assert property (
    @(posedge adc_clock) disable iff (!reset_n)
    !(w_push && !w_pop && (r_count == 2'd2))
  );

endmodule

// File: tb/tb_adc_buffer_reader.sv
// Directed bench for adc_buffer_reader. The capture buffer is modelled as
// read_data = read_addr ^ pat, so sample k is expected to be k ^ pat.
// A second instance with DEPTH=1 covers the single-sample readout.
module tb_adc_buffer_reader;

  localparam int DW = 12;
  localparam int AW = 12;
  localparam int D  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, capture_done, start, abort, m_ready;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data, m_data;
  logic          m_valid, m_last, busy, done;
  logic [DW-1:0] pat;

  logic          start1, abort1, ready1;
  logic [0:0]    read_addr1;
  logic [DW-1:0] read_data1, m_data1;
  logic          m_valid1, m_last1, busy1, done1;

  assign read_data  = read_addr ^ pat;
  assign read_data1 = {{(DW-1){1'b0}}, read_addr1} ^ pat;

  adc_buffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .adc_clock(clk), .reset_n(rst_n), .capture_done(capture_done),
    .start_readout(start), .abort(abort), .read_addr(read_addr),
    .read_data(read_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .readout_done(done));

  adc_buffer_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .DEPTH(1)) dut1 (
    .adc_clock(clk), .reset_n(rst_n), .capture_done(capture_done),
    .start_readout(start1), .abort(abort1), .read_addr(read_addr1),
    .read_data(read_data1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(ready1), .m_last(m_last1), .busy(busy1), .readout_done(done1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the start edge E0.
  task automatic start_ro(input logic cd);
    @(negedge clk);
    capture_done = cd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expects samples 0..D-1 in order; checks hold-stability during stalls.
  task automatic drain(input bit rnd, input string tag);
    int exp_k = 0;
    int cyc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [DW-1:0] e;
    while (exp_k < D && cyc < 20000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        check({tag, " hold valid"}, 32'(m_valid), 32'd1);
        check({tag, " hold data"},  32'(m_data),  32'(pd));
        check({tag, " hold last"},  32'(m_last),  32'(pl));
      end
      if (m_valid && m_ready) begin
        e = DW'(exp_k) ^ pat;
        check({tag, " data"}, 32'(m_data), 32'(e));
        check({tag, " last"}, 32'(m_last), 32'(exp_k == D - 1));
        exp_k++;
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      cyc++;
      @(negedge clk);
    end
    check({tag, " count"}, 32'(exp_k), 32'(D));
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " done end"}, 32'(done), 32'd1);
    m_ready = 1'b1;
  endtask

  initial begin
    int n;
    int cyc;
    rst_n = 1'b0; capture_done = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b0; pat = '0;

    // Reset values
    #12;
    check("rst read_addr", 32'(read_addr), 32'd0);
    check("rst m_valid",   32'(m_valid),   32'd0);
    check("rst m_data",    32'(m_data),    32'd0);
    check("rst m_last",    32'(m_last),    32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-rate readout of a ramp
    pat = 12'h000;
    m_ready = 1'b1;
    start_ro(1'b1);
    check("t1 busy E0", 32'(busy), 32'd1);
    check("t1 valid E0", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t1 valid E1", 32'(m_valid), 32'd0);
    check("t1 addr E1", 32'(read_addr), 32'd0);
    @(negedge clk);
    for (int k = 0; k < D; k++) begin
      check("t1 valid", 32'(m_valid), 32'd1);
      check("t1 data", 32'(m_data), 32'(k));
      check("t1 last", 32'(m_last), 32'(k == D - 1));
      @(negedge clk);
    end
    check("t1 busy end", 32'(busy), 32'd0);
    check("t1 done end", 32'(done), 32'd1);
    check("t1 valid end", 32'(m_valid), 32'd0);

    // Start without capture_done is ignored
    start_ro(1'b0);
    check("t4 busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t4 valid", 32'(m_valid), 32'd0);
    check("t4 busy later", 32'(busy), 32'd0);
    check("t4 done kept", 32'(done), 32'd1);

    // Random backpressure; capture_done drops mid-readout
    pat = 12'h5A5;
    start_ro(1'b1);
    check("t2 busy", 32'(busy), 32'd1);
    check("t2 done cleared", 32'(done), 32'd0);
    capture_done = 1'b0;
    drain(1'b1, "t2");

    // Held off for 20 cycles after start
    pat = 12'h3C3;
    m_ready = 1'b0;
    start_ro(1'b1);
    repeat (20) @(negedge clk);
    check("t3 read_addr", 32'(read_addr), 32'd1);
    check("t3 valid", 32'(m_valid), 32'd1);
    check("t3 data", 32'(m_data), 32'(pat));
    check("t3 busy", 32'(busy), 32'd1);
    drain(1'b0, "t3");

    // Abort at transfer 100
    pat = 12'h0F0;
    m_ready = 1'b1;
    start_ro(1'b1);
    n = 0; cyc = 0;
    while (cyc < 300) begin
      if (m_valid) begin
        if (n == 100) begin
          check("ab data", 32'(m_data), 32'(DW'(100) ^ pat));
          abort = 1'b1;
          break;
        end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    check("ab reached", 32'(n), 32'd100);
    @(negedge clk);
    abort = 1'b0;
    check("ab valid", 32'(m_valid), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab done", 32'(done), 32'd0);
    start_ro(1'b1);
    drain(1'b1, "ab restart");

    // Asynchronous reset mid-readout
    pat = 12'hA0A;
    start_ro(1'b1);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr read_addr", 32'(read_addr), 32'd0);
    check("mr m_valid",   32'(m_valid),   32'd0);
    check("mr m_data",    32'(m_data),    32'd0);
    check("mr m_last",    32'(m_last),    32'd0);
    check("mr busy",      32'(busy),      32'd0);
    check("mr done",      32'(done),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_ro(1'b1);
    drain(1'b0, "mr restart");

    // DEPTH=1 instance
    pat = 12'h7E1;
    @(negedge clk);
    capture_done = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("d1 busy", 32'(busy1), 32'd1);
    @(negedge clk);
    check("d1 valid E1", 32'(m_valid1), 32'd0);
    check("d1 addr E1", 32'(read_addr1), 32'd0);
    @(negedge clk);
    check("d1 valid", 32'(m_valid1), 32'd1);
    check("d1 last", 32'(m_last1), 32'd1);
    check("d1 data", 32'(m_data1), 32'(pat));
    ready1 = 1'b1;
    @(negedge clk);
    check("d1 valid end", 32'(m_valid1), 32'd0);
    check("d1 busy end", 32'(busy1), 32'd0);
    check("d1 done end", 32'(done1), 32'd1);
    check("d1 addr end", 32'(read_addr1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
